// File: rtl/burst_ram_pkg.sv
// burst_ram_pkg: shared types and constants for the PSRAM burst-memory stand-in
package burst_ram_pkg;
  typedef enum logic [1:0] {IDLE, WRITE_BURST, READ_WAIT, READ_BURST} state_t;
  localparam int BURST_BEATS = 4;
  localparam int BEAT_BITWIDTH = 64;
  localparam int BEAT_IX_BITWIDTH = 2;
endpackage

// File: rtl/burst_ram_array.sv
// burst_ram_array: byte-enabled simple dual-port word storage with a registered read port
module burst_ram_array
  import burst_ram_pkg::*;
#(
  parameter int WORD_BITS = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [WORD_BITS-1:0]       waddr,
  input  logic [BEAT_BITWIDTH/8-1:0] wbe,
  input  logic [BEAT_BITWIDTH-1:0]   wdata,
  input  logic                       re,
  input  logic [WORD_BITS-1:0]       raddr,
  output logic [BEAT_BITWIDTH-1:0]   rdata
);
  logic [BEAT_BITWIDTH-1:0] mem [2**WORD_BITS];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < BEAT_BITWIDTH/8; i++)
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  // Read register doubles as the visible rd_data: it holds the last beat and clears on reset.
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/burst_ram.sv
// burst_ram: PSRAM burst-memory stand-in with 4-beat bursts, command interval,
// read latency and calibration timing, flagging rejected commands
module burst_ram
  import burst_ram_pkg::*;
#(
  parameter int ADDRESS_BITWIDTH = 21,
  parameter int READ_LATENCY = 8,
  parameter int COMMAND_INTERVAL = 14,
  parameter int CALIB_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd,
  input  logic                        cmd_en,
  input  logic [ADDRESS_BITWIDTH-1:0] addr,
  input  logic [BEAT_BITWIDTH-1:0]    wr_data,
  input  logic [7:0]                  data_mask,
  output logic [BEAT_BITWIDTH-1:0]    rd_data,
  output logic                        rd_data_valid,
  output logic                        init_calib,
  output logic                        busy,
  output logic                        cmd_error
);
  localparam int WB = ADDRESS_BITWIDTH - 3;
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam int IW = $clog2(COMMAND_INTERVAL + 1);
  localparam int CW = $clog2(CALIB_CYCLES + 1);
  state_t state;
  logic [BEAT_IX_BITWIDTH-1:0] beat, lo;
  logic [WB-1:0] base, idx, baddr;
  logic [LW-1:0] lat;
  logic [IW-1:0] ivl;
  logic [CW-1:0] cal;
  logic accept, we, re, unused;
  assign unused = ^addr[2:0];
  assign idx = addr[ADDRESS_BITWIDTH-1:3];
  assign lo = base[1:0] + beat;
  assign baddr = {base[WB-1:2], lo};
  assign accept = cmd_en && !rst && init_calib && state == IDLE && ivl == '0;
  assign we = !rst && (accept && cmd || state == WRITE_BURST);
  // Beat reads are issued one cycle early to absorb the array's registered read.
  assign re = !rst && (state == READ_BURST || state == READ_WAIT && lat == LW'(READ_LATENCY - 1));
  assign busy = state != IDLE || ivl != '0;
  burst_ram_array #(.WORD_BITS(WB)) u_array (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(accept ? idx : baddr),
    .wbe(~data_mask),
    .wdata(wr_data),
    .re(re),
    .raddr(baddr),
    .rdata(rd_data)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      beat <= '0;
      base <= '0;
      lat <= '0;
      ivl <= '0;
      cal <= '0;
      init_calib <= 1'b0;
      cmd_error <= 1'b0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= re;
      if (!init_calib) begin
        cal <= cal + 1'b1;
        init_calib <= cal == CW'(CALIB_CYCLES - 1);
      end
      if (cmd_en && !accept) cmd_error <= 1'b1;
      if (ivl != '0) ivl <= ivl - 1'b1;
      case (state)
        IDLE: if (accept) begin
          state <= cmd ? WRITE_BURST : READ_WAIT;
          base <= idx;
          beat <= BEAT_IX_BITWIDTH'(cmd);
          lat <= LW'(1);
          ivl <= IW'(COMMAND_INTERVAL - 1);
        end
        READ_WAIT: begin
          lat <= lat + 1'b1;
          if (re) begin
            state <= READ_BURST;
            beat <= BEAT_IX_BITWIDTH'(1);
          end
        end
        WRITE_BURST, READ_BURST: begin
          beat <= beat + 1'b1;
          if (beat == BEAT_IX_BITWIDTH'(BURST_BEATS - 1)) state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_burst_ram.sv
// tb_burst_ram: randomized scoreboard bench for burst_ram against a word-array reference model
module tb_burst_ram;
  logic clk = 0, rst = 1, cmd = 0, cmd_en = 0;
  logic [20:0] addr = '0;
  logic [63:0] wr_data = '0, rd_data;
  logic [7:0] data_mask = '0;
  logic rd_data_valid, init_calib, busy, cmd_error;
  int checks = 0, errors = 0, cyc = 0, t0 = 0;
  typedef struct {logic [63:0] d; int c;} exp_t;
  exp_t q[$];
  logic [63:0] model [128];

  burst_ram dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
    .wr_data(wr_data), .data_mask(data_mask), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .init_calib(init_calib), .busy(busy), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", n, cyc, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat k of a burst lands in the aligned 4-word block, wrapping from the start word.
  function automatic int wix(input logic [20:0] a, input int k);
    int w = int'(a >> 3);
    return (w & ~3) | ((w + k) & 3);
  endfunction

  function automatic void wbeat(input logic [20:0] a, input int k, input logic [63:0] d, input logic [7:0] m);
    for (int b = 0; b < 8; b++)
      if (!m[b]) model[wix(a, k)][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic go(input bit c, input logic [20:0] a, input logic [3:0][63:0] d, input logic [3:0][7:0] m, input bit ok);
    t0 = cyc;
    cmd = c;
    addr = a;
    cmd_en = 1;
    if (ok && !c)
      for (int k = 0; k < 4; k++) q.push_back('{model[wix(a, k)], t0 + 8 + k});
    for (int k = 0; k < (c ? 4 : 1); k++) begin
      wr_data = d[k];
      data_mask = m[k];
      if (ok && c) wbeat(a, k, d[k], m[k]);
      tick();
      cmd_en = 0;
    end
  endtask

  task automatic gap(input int n);
    while (cyc < t0 + n) tick();
  endtask

  task automatic release_rst();
    rst = 0;
    for (int i = 0; i < 40 && !init_calib; i++) tick();
    chk("calib_ready", init_calib, 1);
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    q.delete();
    chk("rst_rd_data", rd_data, 0);
    chk("rst_valid", rd_data_valid, 0);
    chk("rst_calib", init_calib, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_error", cmd_error, 0);
    release_rst();
  endtask

  always @(negedge clk) begin
    if (q.size() != 0 && q[0].c < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_beat: no rd_data_valid at cycle %0d, expected data %h", q[0].c, q[0].d);
      void'(q.pop_front());
    end
    if (rd_data_valid) begin
      if (q.size() == 0 || q[0].c != cyc) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat at cycle %0d: rd_data_valid=1 data %h, none due", cyc, rd_data);
      end else begin
        chk("rd_data", rd_data, q[0].d);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0][63:0] d;
    logic [3:0][7:0] m;
    int t;
    tick(); tick(); tick();
    chk("rst_rd_data", rd_data, 0);
    chk("rst_valid", rd_data_valid, 0);
    chk("rst_calib", init_calib, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_error", cmd_error, 0);
    rst = 0;
    addr = 21'h40;
    cmd = 0;
    for (int k = 1; k <= 20; k++) begin
      cmd_en = (k == 5);
      if (k == 16 || k == 17) chk("init_calib_edge", init_calib, k >= 17);
      if (k == 6) chk("early_cmd_error", cmd_error, 1);
      tick();
    end
    cmd_en = 0;
    m = '0;
    for (int b = 0; b < 32; b++) begin
      for (int k = 0; k < 4; k++) d[k] = rnd64();
      go(1, 21'(b * 32), d, m, 1);
      gap(14 + int'($urandom_range(0, 3)));
    end
    d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    go(1, 21'h40, d, m, 1);
    gap(14);
    go(0, 21'h40, d, m, 1);
    gap(14);
    for (int k = 0; k < 4; k++) d[k] = rnd64();
    go(1, 21'h50, d, m, 1);
    gap(14);
    chk("wrap_word8", model[8], d[2]);
    chk("wrap_word10", model[10], d[0]);
    go(0, 21'h40, d, m, 1);
    gap(14);
    d = {4{64'hFFFF_FFFF_FFFF_FFFF}};
    go(1, 21'h60, d, m, 1);
    gap(14);
    for (int k = 0; k < 4; k++) d[k] = rnd64();
    m[1] = 8'h0F;
    go(1, 21'h60, d, m, 1);
    gap(14);
    chk("mask_word13", model[13], {d[1][63:32], 32'hFFFF_FFFF});
    go(0, 21'h60, d, m, 1);
    gap(14);
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 4; k++) begin
        d[k] = rnd64();
        m[k] = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
      end
      go(1'($urandom_range(0, 1)), 21'($urandom_range(0, 'h3FF)), d, m, 1);
      gap(14 + int'($urandom_range(0, 3)));
    end
    do_reset();
    m = '0;
    go(0, 21'h40, d, m, 1);
    t = t0;
    while (cyc < t + 13) tick();
    chk("interval_busy", busy, 1);
    chk("interval_err_before", cmd_error, 0);
    cmd = 1;
    addr = 21'h40;
    wr_data = rnd64();
    cmd_en = 1;
    tick();
    cmd_en = 0;
    chk("interval_err_after", cmd_error, 1);
    go(0, 21'h40, d, m, 1);
    gap(14);
    go(0, 21'h60, d, m, 1);
    while (cyc < t0 + 10) tick();
    rst = 1;
    tick();
    q.delete();
    chk("abort_read_valid", rd_data_valid, 0);
    tick();
    chk("abort_read_valid2", rd_data_valid, 0);
    chk("abort_read_data", rd_data, 0);
    release_rst();
    cmd = 1;
    addr = 21'h60;
    cmd_en = 1;
    for (int k = 0; k < 2; k++) begin
      wr_data = rnd64();
      data_mask = 0;
      wbeat(21'h60, k, wr_data, 8'h00);
      tick();
      cmd_en = 0;
    end
    rst = 1;
    wr_data = rnd64();
    tick();
    tick();
    release_rst();
    go(0, 21'h60, d, m, 1);
    gap(20);
    chk("queue_drained", 64'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/burst_ram.md
Name: burst_ram

Overview:
Synthesizable and simulatable stand-in for the PSRAM burst-memory IP. It sits directly downstream of the cache's `br_*` port.
- Accepts one read or write command at a time.
- Each command transfers a 4-beat burst of 64-bit words (one 32-byte cache line).
- Enforces the IP's command-interval and read-latency timing.
- Flags protocol violations so benches can check the cache's sequencing.

Parameters:
- ADDRESS_BITWIDTH, 21, byte address width of `addr`; storage is 2^(ADDRESS_BITWIDTH-3) 64-bit words.
- READ_LATENCY, 8, cycles from the `cmd_en` cycle to the first `rd_data_valid` beat (minimum 2).
- COMMAND_INTERVAL, 14, minimum cycles from one accepted `cmd_en` to the next.
- CALIB_CYCLES, 16, cycles after reset release before `init_calib` rises.

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- cmd  in  1  0: read, 1: write; sampled with `cmd_en`
- cmd_en  in  1  single-cycle command strobe
- addr  in  ADDRESS_BITWIDTH  byte address of burst start; sampled with `cmd_en`
- wr_data  in  64  write beat data; beat 0 in the `cmd_en` cycle, beats 1..3 in the next 3 cycles
- data_mask  in  8  per-beat byte mask; bit i = 1 leaves byte i unwritten
- rd_data  out  64  read beat data
- rd_data_valid  out  1  high for exactly 4 consecutive cycles per read
- init_calib  out  1  high once the memory is ready for commands
- busy  out  1  high while a burst is active or the interval counter is nonzero
- cmd_error  out  1  sticky; set on any rejected command

Behaviour:
- Reset values:
  - `rd_data` = 0, `rd_data_valid` = 0, `init_calib` = 0, `busy` = 0, `cmd_error` = 0.
  - FSM = IDLE; counters = 0; memory contents are not cleared.
- Calibration:
  - The counter starts on the first cycle with `rst` low.
  - `init_calib` rises after CALIB_CYCLES cycles and stays high until the next reset.
- Command acceptance: `cmd_en` is accepted only when `init_calib` = 1, FSM = IDLE and the interval counter = 0.
- Rejection: any other `cmd_en` is ignored (no memory change, no read data) and sets `cmd_error`.
- On accept:
  - Interval counter loads COMMAND_INTERVAL-1 and decrements each cycle to 0.
  - `busy` asserts the following cycle.
- Beat addressing:
  - Word index = `addr[ADDRESS_BITWIDTH-1:3]`; low bits `addr[2:0]` are ignored.
  - Beat k accesses word {index[top:2], index[1:0]+k}, i.e. wrap within the aligned 4-word block.
- FSM states: IDLE, WRITE_BURST, READ_WAIT, READ_BURST.
  - IDLE --accept write--> WRITE_BURST. Beat 0 (`wr_data`/`data_mask`) is written in the accept cycle. Beats 1..3 are written in the next 3 cycles, then the FSM returns to IDLE.
  - IDLE --accept read--> READ_WAIT. A latency counter runs; the first beat appears READ_LATENCY cycles after `cmd_en`.
  - READ_WAIT --> READ_BURST. `rd_data_valid` = 1 with beats 0..3 on 4 consecutive cycles, then `rd_data_valid` = 0 and the FSM returns to IDLE. `rd_data` holds the last beat afterwards.
- Read data reflects memory contents at the time of the beat. A read never overlaps a write because the interval exceeds the burst length.
- `cmd` value is ignored when `cmd_en` = 0.
- `busy` = (FSM != IDLE) or (interval counter != 0).
- Reset mid-burst: the next cycle returns to reset values. Remaining write beats are not written; no further `rd_data_valid`.
- `cmd_error` clears only on `rst`.

Decomposition:
- Package `burst_ram_pkg`:
  - state enum (IDLE, WRITE_BURST, READ_WAIT, READ_BURST)
  - BURST_BEATS = 4
  - BEAT_BITWIDTH = 64
  - BEAT_IX_BITWIDTH = 2
- One sub-module, `burst_ram_array`: 64-bit wide, byte-enabled, simple dual-port storage.
  - Write port: word address, 8-bit active-high byte enable (= ~`data_mask`).
  - Read port: registered.
  - The top level compensates its 1-cycle read latency inside READ_WAIT.

Test Plan:
- Reset release -> `init_calib` = 0 for 16 cycles and 1 from cycle 17; a `cmd_en` at cycle 5 is ignored and sets `cmd_error`.
- Write at `addr` 0x000040, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44, mask 0 -> after the interval, a read at 0x000040 returns those 4 beats in order, first `rd_data_valid` exactly 8 cycles after `cmd_en`, valid for exactly 4 cycles.
- Write at 0x000050, beats A,B,C,D -> words 0x0A, 0x0B, 0x08, 0x09 hold A, B, C, D; a read at 0x000040 returns C, D, A, B.
- Write with beat-1 `data_mask` 0x0F over a prior 0xFFFF_FFFF_FFFF_FFFF -> read beat 1 = {new[63:32], 0xFFFF_FFFF}.
- Read accepted at cycle t, second `cmd_en` at t+13 -> rejected, `cmd_error` = 1, `busy` was 1; `cmd_en` at t+14 -> accepted.
- `rst` asserted during read beat 2 -> `rd_data_valid` = 0 next cycle and stays 0; a write aborted after beat 1 leaves beats 2..3 unchanged in memory.
